// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encodings, immediate formats
// and the decoded bundle carried from decode into execute.
package riscv_pkg;

  localparam int XLEN_C = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operation codes; 11..15 are reserved
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } decoded_t;

  // Build the sign-extended immediate for the given format.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // Map funct3 (plus the funct7[5] alternate bit) onto an ALU operation.
  // 'alt_sub' selects SUB for funct3=000 (register form only); 'alt_sra'
  // selects SRA for funct3=101.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                 input logic       alt_sub,
                                                 input logic       alt_sra);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Purely combinational RV32I decoder: instruction word + PC -> decoded bundle.
module rv_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  imm_fmt_e   fmt_s;
  logic [6:0] opcode_s;
  logic       rw_s;

  assign opcode_s = instr[6:0];

  // Opcode decode into format, ALU op and control flags
  always_comb begin
    dec           = '0;
    fmt_s         = IMM_NONE;
    rw_s          = 1'b0;
    dec.pc        = pc;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.alu_op    = ALU_ADD;
    case (opcode_s)
      OPC_LUI: begin
        fmt_s      = IMM_U;
        dec.alu_op = ALU_PASSB;
        rw_s       = 1'b1;
      end
      OPC_AUIPC: begin
        fmt_s      = IMM_U;
        dec.alu_op = ALU_ADD;
        rw_s       = 1'b1;
      end
      OPC_JAL: begin
        fmt_s    = IMM_J;
        dec.jump = 1'b1;
        rw_s     = 1'b1;
      end
      OPC_JALR: begin
        fmt_s    = IMM_I;
        dec.jump = 1'b1;
        rw_s     = 1'b1;
      end
      OPC_BRANCH: begin
        fmt_s      = IMM_B;
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        fmt_s        = IMM_I;
        dec.mem_read = 1'b1;
        rw_s         = 1'b1;
        dec.alu_op   = ALU_ADD;
      end
      OPC_STORE: begin
        fmt_s         = IMM_S;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OPC_OPIMM: begin
        fmt_s      = IMM_I;
        rw_s       = 1'b1;
        // No SUBI exists; only the shift form uses funct7[5]
        dec.alu_op = alu_from_funct3(instr[14:12], 1'b0, instr[30]);
      end
      OPC_OP: begin
        fmt_s      = IMM_NONE;
        rw_s       = 1'b1;
        dec.alu_op = alu_from_funct3(instr[14:12], instr[30], instr[30]);
      end
      default: begin
        fmt_s       = IMM_NONE;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = imm_gen(instr, fmt_s);
    // Writes to x0 are architecturally discarded, so never request one
    dec.reg_write = rw_s & (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: main + skid output registers with a registered
// in_ready, an occupancy FSM and flush support.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e     state_q, state_d;
  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  logic     in_ready_q, in_ready_d;
  logic     out_valid_q, out_valid_d;
  decoded_t dec_s;
  logic     accept_s;
  logic     pop_s;

  rv_decoder u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_s)
  );

  assign accept_s = in_valid & in_ready_q;
  assign pop_s    = out_valid_q & out_ready;

  // Occupancy next-state, register loads and registered handshake signals
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = dec_s;
          state_d = ST_MAIN;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_MAIN: begin
        if (accept_s && pop_s) begin
          main_d  = dec_s;
          state_d = ST_MAIN;
        end else if (accept_s) begin
          skid_d  = dec_s;
          state_d = ST_FULL;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_MAIN;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path exists
        if (pop_s) begin
          main_d  = skid_q;
          state_d = ST_MAIN;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      // Drop everything, including a same-cycle accept; data may go stale
      // but no control flag may survive except the illegal marker
      state_d          = ST_EMPTY;
      main_d.reg_write = 1'b0;
      main_d.mem_read  = 1'b0;
      main_d.mem_write = 1'b0;
      main_d.branch    = 1'b0;
      main_d.jump      = 1'b0;
    end else begin
      main_d = main_d;
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and bundle registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = main_q.pc;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_alu_op    = main_q.alu_op;
  assign out_reg_write = main_q.reg_write;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_branch    = main_q.branch;
  assign out_jump      = main_q.jump;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;

  int errors_r;
  int checks_r;

  id_stage #(.XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_alu_op    (out_alu_op),
    .out_reg_write (out_reg_write),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_branch    (out_branch),
    .out_jump      (out_jump),
    .out_illegal   (out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flags packed as {reg_write, mem_read, mem_write, branch, jump, illegal}
  function automatic logic [31:0] flags_now();
    return {26'd0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (got !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction with out_ready=1 and check the bundle one cycle later
  task automatic dec_vec(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [3:0] alu, input logic [5:0] flg);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("dec_valid", {31'd0, out_valid}, 32'd1);
    check_eq("dec_pc",    out_pc, pc);
    check_eq("dec_rs1",   {27'd0, out_rs1}, {27'd0, rs1});
    check_eq("dec_rs2",   {27'd0, out_rs2}, {27'd0, rs2});
    check_eq("dec_rd",    {27'd0, out_rd}, {27'd0, rd});
    check_eq("dec_imm",   out_imm, imm);
    check_eq("dec_alu",   {28'd0, out_alu_op}, {28'd0, alu});
    check_eq("dec_flags", flags_now(), {26'd0, flg});
  endtask

  // Fill both registers while the consumer is stalled
  task automatic fill_full(input logic [31:0] i0, input logic [31:0] i1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = i0;
    in_pc     = 32'h0000_0040;
    tick();
    in_instr  = i1;
    in_pc     = 32'h0000_0044;
    tick();
    in_valid  = 1'b0;
    check_eq("fill_inready", {31'd0, in_ready}, 32'd0);
  endtask

  logic [31:0] pcs [4];
  logic [31:0] got_pc;
  logic        acc_b, pop_b;
  int          idx_in, n_out;

  initial begin
    errors_r  = 0;
    checks_r  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_valid",   {31'd0, out_valid}, 32'd0);
    check_eq("rst_inready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_pc",      out_pc, 32'h0);
    check_eq("rst_imm",     out_imm, 32'h0);
    check_eq("rst_flags",   flags_now(), 32'h0);

    // Decode vectors (back to back, consumer always ready)
    dec_vec(32'h0050_0093, 32'h0000_0000, 5'd0, 5'd5, 5'd1,  32'h0000_0005, 4'd0,  6'b100000); // addi x1,x0,5
    dec_vec(32'h0020_A423, 32'h0000_0004, 5'd1, 5'd2, 5'd8,  32'h0000_0008, 4'd0,  6'b001000); // sw x2,8(x1)
    dec_vec(32'hFE00_0EE3, 32'h0000_0008, 5'd0, 5'd0, 5'd29, 32'hFFFF_FFFC, 4'd1,  6'b000100); // beq -4
    dec_vec(32'h0000_0000, 32'h0000_000C, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 4'd0,  6'b000001); // illegal
    dec_vec(32'h1234_52B7, 32'h0000_0010, 5'd8, 5'd3, 5'd5,  32'h1234_5000, 4'd10, 6'b100000); // lui x5
    dec_vec(32'h0000_006F, 32'h0000_0014, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 4'd0,  6'b000010); // jal x0,0
    dec_vec(32'h4021_D193, 32'h0000_0018, 5'd3, 5'd2, 5'd3,  32'h0000_0402, 4'd7,  6'b100000); // srai x3,x3,2
    dec_vec(32'h4062_8233, 32'h0000_001C, 5'd5, 5'd6, 5'd4,  32'h0000_0000, 4'd1,  6'b100000); // sub x4,x5,x6
    out_ready = 1'b1;
    tick();
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

    // Stream four PCs with a 3-cycle consumer stall
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    idx_in = 0;
    n_out  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (n_out == 4) break;
      in_valid  = (idx_in < 4);
      in_instr  = 32'h0050_0093;
      in_pc     = (idx_in < 4) ? pcs[idx_in] : 32'h0;
      out_ready = (cyc >= 3);
      acc_b  = in_valid & in_ready;
      pop_b  = out_valid & out_ready;
      got_pc = out_pc;
      tick();
      if (pop_b) begin
        check_eq("stream_order", got_pc, pcs[n_out]);
        n_out = n_out + 1;
      end
      if (acc_b) idx_in = idx_in + 1;
      if (cyc == 0) check_eq("stream_inready1", {31'd0, in_ready}, 32'd1);
      if (cyc == 1) check_eq("stream_inready2", {31'd0, in_ready}, 32'd0);
      if (cyc == 1 || cyc == 2) begin
        check_eq("stall_pc",  out_pc, 32'h0);
        check_eq("stall_imm", out_imm, 32'h5);
      end
    end
    in_valid = 1'b0;
    check_eq("stream_count", n_out, 32'd4);

    // Flush while full, with an instruction presented in the same cycle
    fill_full(32'h0050_0093, 32'h0020_A423);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    in_pc    = 32'h0000_0100;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid",   {31'd0, out_valid}, 32'd1 - 32'd1);
    check_eq("flush_inready", {31'd0, in_ready}, 32'd1);
    check_eq("flush_flags",   flags_now() & 32'h3E, 32'h0);
    out_ready = 1'b1;
    tick();
    check_eq("flush_gone", {31'd0, out_valid}, 32'd0);

    // Flush while holding one entry: the same-cycle accept must vanish
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0093;
    in_pc     = 32'h0000_0200;
    tick();
    flush    = 1'b1;
    in_pc    = 32'h0000_0204;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("flush1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check_eq("flush1_gone", {31'd0, out_valid}, 32'd0);

    // Reset while full
    fill_full(32'h0050_0093, 32'h0000_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_valid",   {31'd0, out_valid}, 32'd0);
    check_eq("mrst_inready", {31'd0, in_ready}, 32'd1);
    check_eq("mrst_flags",   flags_now(), 32'h0);
    check_eq("mrst_pc",      out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check_eq("mrst_gone", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage sitting directly downstream of the instruction fetch unit in the RV32I core.
- Accepts each fetched 32-bit instruction and its PC through a valid/ready handshake, then decodes it.
- Holds up to two decoded entries: a main output register plus a skid register. This keeps in_ready registered and still sustains one instruction per cycle.
- Presents a registered decoded bundle to the execute stage. Supports pipeline flush on branch redirect.

Parameters:
XLEN, 32, datapath/PC width (only 32 supported)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; registered
in_instr  in  32  instruction word
in_pc  in  32  PC of in_instr
flush  in  1  discard all held and incoming instructions
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
out_pc  out  32  PC of decoded instruction
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_imm  out  32  sign-extended immediate
out_alu_op  out  4  ALU operation code
out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  control flags
out_illegal  out  1  unsupported opcode

Behaviour:
- Reset state: synchronous on reset=1.
  - Occupancy = EMPTY; out_valid=0; in_ready=1.
  - All out_* data fields and flags = 0.
- Transfers:
  - Accept when in_valid & in_ready.
  - Output handshake when out_valid & out_ready.
  - Decode is combinational on in_instr. The decoded result is captured into the main register or the skid register at accept.
- Occupancy FSM:
  - EMPTY: accept -> MAIN.
  - MAIN:
    - accept & !pop -> FULL (new entry to skid).
    - accept & pop -> MAIN (new entry to main).
    - pop only -> EMPTY.
  - FULL:
    - pop -> MAIN (skid moves to main).
    - in_ready=0, so no accept is possible.
- Ready and ordering:
  - in_ready = (next state != FULL), registered.
  - Strict in-order delivery; no instruction is lost or duplicated under any out_ready pattern.
  - Bundle outputs must not change while out_valid=1 & out_ready=0.
- Flush:
  - Highest priority below reset.
  - Next state EMPTY, out_valid=0, in_ready=1.
  - Any instruction accepted in the flush cycle is discarded.
  - Data fields may hold stale values, but all flags except out_illegal clear to 0.
- Decode by opcode[6:0]:
  - LUI 0110111: U-imm, alu PASSB, reg_write.
  - AUIPC 0010111: U-imm, alu ADD, reg_write.
  - JAL 1101111: J-imm, jump, reg_write.
  - JALR 1100111: I-imm, jump, reg_write.
  - BRANCH 1100011: B-imm, branch, alu SUB.
  - LOAD 0000011: I-imm, mem_read, reg_write, alu ADD.
  - STORE 0100011: S-imm, mem_write, alu ADD.
  - OP-IMM 0010011: I-imm, reg_write, alu from funct3; SRAI when funct7[5]=1.
  - OP 0110011: imm=0, reg_write, alu from funct3/funct7[5].
  - Any other opcode: out_illegal=1 and all other flags 0.
- Immediates:
  - I, S, B, U and J formats per RV32I, sign-extended from instr[31].
  - B and J immediates have bit0=0.
  - U immediate has low 12 bits = 0.
- alu_op encoding: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10; 11-15 are reserved.
- Register fields:
  - rs1, rs2 and rd are always extracted raw from instr[19:15], [24:20] and [11:7].
  - reg_write is forced to 0 when rd=0.
- Reset asserted mid-operation: behaves identically to power-on reset in the following cycle; all held entries are dropped.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants;
  - alu_op encodings;
  - an immediate-format enum (I/S/B/U/J/NONE);
  - a decoded-bundle struct (pc, rs1, rs2, rd, imm, alu_op, flags).
- Sub-module rv_decoder: purely combinational instr -> decoded bundle, reused for both capture paths.
- id_stage contains only the two registers, the occupancy FSM and the handshake logic.

Test Plan:
- Load 0x00500093 (addi x1,x0,5) at pc=0x0 with out_ready=1 -> one cycle later:
  - out_valid=1, rd=1, rs1=0, imm=0x00000005, alu_op=0, reg_write=1.
- Load 0x0020A423 (sw x2,8(x1)) -> rs1=1, rs2=2, imm=0x00000008, mem_write=1, reg_write=0.
- Load 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, alu_op=1. Load 0x00000000 -> out_illegal=1, all other flags 0.
- Stream PCs 0x0, 0x4, 0x8, 0xC with out_ready=0 for 3 cycles, then 1 ->
  - in_ready falls after 2 accepts;
  - outputs stay stable while stalled;
  - all four emerge in PC order.
- Stage FULL, then pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never appears.
- Assert reset for 1 cycle while FULL -> next cycle out_valid=0, in_ready=1, all flags 0.
